trig_sequencer: RTL and testbench
=================================

# trig_sequencer

- Power-on and frame trigger scheduler for the ECT board.
- After reset it releases the active-low resets of `NCH` subsystems one at a time, at fixed tick-based intervals. It then raises `Ready`.
- While `Start` is high it issues periodic single-cycle `FrameTrig` pulses to the measurement datapath. A trigger is deferred while the datapath reports `FrameBusy`.
- It sits between the reset button and every subsystem that needs ordered start-up and frame pacing.

## Interface
- `NCH`, default 4: number of sequenced subsystem resets (1..16).
- `PRE_DIV`, default 400: prescaler length in CLK cycles per tick (2..65535).
- `RST_TICKS`, default 5: ticks for which all subsystem resets are held after reset (1..65535).
- `GAP_TICKS`, default 2: ticks between successive reset releases (1..65535).
- `FRAME_TICKS`, default 100: frame trigger period in ticks (1..65535).
- `CLK`  in  1  system clock, single clock domain.
- `RstBtn`  in  1  reset, synchronous, active-low.
- `Start`  in  1  level; high enables frame triggering.
- `FrameBusy`  in  1  datapath busy; a due trigger is held off while high.
- `SubRstN`  out  NCH  per-subsystem active-low resets; bit 0 is released first.
- `Ready`  out  1  all subsystems released.
- `FrameTrig`  out  1  one-cycle frame trigger pulse.
- `FrameCnt`  out  16  number of triggers issued; wraps 0xFFFF→0.
- `Overrun`  out  1  sticky; a trigger was deferred by `FrameBusy`.

## Operation
- Reset: when `RstBtn` is sampled low, the block returns to `S_HOLD` at that edge.
  - Outputs: `SubRstN`=0, `Ready`=0, `FrameTrig`=0, `FrameCnt`=0, `Overrun`=0.
  - Internals: prescaler=0, tick count=0, channel index=0.
  - Reset mid-operation always restarts the whole sequence.
- Prescaler: 16-bit, counts 0..PRE_DIV-1 and wraps.
  - `tick` is high while prescaler == PRE_DIV-1.
  - Free-running in `S_HOLD`, `S_REL` and `S_RUN`.
  - Cleared on entry to `S_RUN`.
- Tick counter: 16-bit.
  - Increments on each tick and is cleared whenever its target is reached.
  - Targets: `S_HOLD` uses RST_TICKS; `S_REL` uses GAP_TICKS; `S_RUN` uses FRAME_TICKS.
- States:
  - `S_HOLD`: all `SubRstN` low. On the RST_TICKS-th tick, set `SubRstN[0]`=1, set index=1, go to `S_REL`.
  - `S_REL`: on each GAP_TICKS-th tick:
    - if index<NCH: set `SubRstN[index]`=1, index+1;
    - else: set `Ready`=1, go to `S_IDLE`.
    - NCH=1 therefore still waits one gap before `Ready`.
  - `S_IDLE`: no triggers. When `Start` is sampled high:
    - if `FrameBusy` is low: pulse `FrameTrig`, clear prescaler and tick counter, go to `S_RUN`;
    - if `FrameBusy` is high: go to `S_WAIT` and set `Overrun`.
  - `S_RUN`: on the FRAME_TICKS-th tick:
    - if `FrameBusy` is low: pulse `FrameTrig`, restart the period;
    - if `FrameBusy` is high: set `Overrun`, go to `S_WAIT`.
  - `S_WAIT`: prescaler frozen. At the first edge with `FrameBusy` sampled low: pulse `FrameTrig`, clear prescaler and tick counter, go to `S_RUN`.
- `Start` sampled low in `S_RUN` or `S_WAIT`: go to `S_IDLE` at that edge, no further trigger. A pulse already registered is never cut short.
- Once set, `SubRstN` bits and `Ready` stay high until reset.
- `FrameCnt` increments in the same cycle `FrameTrig` is registered high. It wraps silently.
- `Overrun` is cleared only by reset.

## Timing
- Edge numbering: e1 is the first rising edge with `RstBtn` sampled high. Prescaler=1 after e1; tick #k is consumed at edge e(k·PRE_DIV).
- `SubRstN[i]` goes high after edge e(PRE_DIV·(RST_TICKS+i·GAP_TICKS)).
- `Ready` goes high after edge e(PRE_DIV·(RST_TICKS+NCH·GAP_TICKS)).
- All outputs are registered, with no combinational input-to-output path.
- `Start` sampled at edge s in `S_IDLE` with `FrameBusy` low:
  - `FrameTrig` is high for exactly the cycle after s;
  - subsequent triggers follow at s+n·PRE_DIV·FRAME_TICKS while never busy.
- `Start` and `FrameBusy` are ignored before `Ready`.
- Deferred trigger: if busy at the due edge d, `Overrun` goes high after d. The trigger issues after the first edge t>d with `FrameBusy` low, and the next period is measured from t.
- `Start` falling at the same edge a trigger is due: `Start` wins, no trigger issues.

## Test plan
Parameters for all scenarios: PRE_DIV=4, RST_TICKS=2, GAP_TICKS=1, NCH=3, FRAME_TICKS=3.
- Power-up: release reset, hold `Start` low.
  - Required: `SubRstN`=001 after e8, 011 after e12, 111 after e16.
  - Required: `Ready`=1 after e20.
  - Required: `FrameTrig` stays 0 throughout.
- Periodic frames: `Start`=1 sampled at e30, `FrameBusy`=0.
  - Required: one-cycle `FrameTrig` after e30, e42, e54.
  - Required: `FrameCnt` reads 1, 2, 3; `Overrun` stays 0.
- Busy deferral: as above, but `FrameBusy`=1 for edges e41–e45.
  - Required: no trigger at e42; `Overrun`=1 after e42.
  - Required: trigger after e46; next trigger after e58.
- Stop and restart: drop `Start` sampled at e42.
  - Required: no trigger at e42; block returns to idle.
  - Then raise `Start` sampled at e50: required trigger after e50, next after e62.
- Mid-operation reset: assert `RstBtn` low for 1 cycle during `S_RUN`.
  - Required: all outputs 0 after that edge, including `FrameCnt` and `Overrun`.
  - Required: the power-up timing repeats, measured from the new e1.
- Counter wrap: force `FrameCnt` to 0xFFFF via a bench-accelerated run.
  - Required: the next trigger yields `FrameCnt`=0x0000 with no other side effect.

Source files
------------

// File: rtl/trig_if.sv
// Pacing and reset-sequencing signals between trig_sequencer and its
// surroundings. The master modport is the sequencer side.
interface trig_if #(
   parameter int NCH = 4
) ();
   // Start is a level enable. FrameBusy is a level hold-off: a trigger that
   // falls due while it is high is deferred until the first cycle it is low.
   // Every output is a register in the sequencer.
   logic            Start;
   logic            FrameBusy;
   logic [NCH-1:0]  SubRstN;
   logic            Ready;
   logic            FrameTrig;
   logic [15:0]     FrameCnt;
   logic            Overrun;
   logic [2:0]      State;

   modport master (
      input  Start, FrameBusy,
      output SubRstN, Ready, FrameTrig, FrameCnt, Overrun, State
   );

   modport slave (
      output Start, FrameBusy,
      input  SubRstN, Ready, FrameTrig, FrameCnt, Overrun, State
   );
endinterface

// File: rtl/trig_sequencer.sv
// Power-on reset sequencer and frame trigger scheduler: releases subsystem
// resets one by one on prescaled ticks, then paces FrameTrig while Start is high.
module trig_sequencer #(
   parameter int NCH         = 4,
   parameter int PRE_DIV     = 400,
   parameter int RST_TICKS   = 5,
   parameter int GAP_TICKS   = 2,
   parameter int FRAME_TICKS = 100
) (
   input  logic   CLK,
   input  logic   RstBtn,
   trig_if.master bus
);
   typedef enum logic [2:0] {
      S_HOLD = 3'd0,
      S_REL  = 3'd1,
      S_IDLE = 3'd2,
      S_RUN  = 3'd3,
      S_WAIT = 3'd4
   } state_e;

   localparam int             IW       = $clog2(NCH + 1);
   localparam logic [IW-1:0]  NCH_I    = IW'(NCH);
   localparam logic [15:0]    PRE_LAST = 16'(PRE_DIV - 1);
   localparam logic [15:0]    RST_T    = 16'(RST_TICKS);
   localparam logic [15:0]    GAP_T    = 16'(GAP_TICKS);
   localparam logic [15:0]    FRAME_T  = 16'(FRAME_TICKS);

   state_e          state_q;
   logic [15:0]     presc_q, presc_d;
   logic [15:0]     tcnt_q, tcnt_d;
   logic [IW-1:0]   idx_q;
   logic [NCH-1:0]  sub_rst_n_q;
   logic            ready_q;
   logic            trig_q;
   logic [15:0]     frame_cnt_q;
   logic            overrun_q;
   logic            tick;
   logic            tgt_hit;
   logic [15:0]     target;

   // The tick counter's target depends on the phase of the sequence.
   always_comb begin
      tick    = (presc_q == PRE_LAST);
      presc_d = tick ? 16'd0 : presc_q + 16'd1;
      case (state_q)
         S_HOLD:  target = RST_T;
         S_REL:   target = GAP_T;
         default: target = FRAME_T;
      endcase
      tgt_hit = tick && (tcnt_q == target - 16'd1);
      tcnt_d  = tcnt_q;
      if (tick) tcnt_d = tgt_hit ? 16'd0 : tcnt_q + 16'd1;
   end

   always_ff @(posedge CLK) begin
      if (!RstBtn) begin
         state_q     <= S_HOLD;
         presc_q     <= 16'd0;
         tcnt_q      <= 16'd0;
         idx_q       <= '0;
         sub_rst_n_q <= '0;
         ready_q     <= 1'b0;
         trig_q      <= 1'b0;
         frame_cnt_q <= 16'd0;
         overrun_q   <= 1'b0;
      end else begin
         trig_q  <= 1'b0;
         presc_q <= presc_d;
         tcnt_q  <= tcnt_d;
         case (state_q)
            S_HOLD: begin
               if (tgt_hit) begin
                  sub_rst_n_q[0] <= 1'b1;
                  idx_q          <= IW'(1);
                  state_q        <= S_REL;
               end
            end
            S_REL: begin
               if (tgt_hit) begin
                  if (idx_q < NCH_I) begin
                     for (int i = 0; i < NCH; i++)
                        if (idx_q == IW'(i)) sub_rst_n_q[i] <= 1'b1;
                     idx_q <= idx_q + IW'(1);
                  end else begin
                     ready_q <= 1'b1;
                     state_q <= S_IDLE;
                  end
               end
            end
            S_IDLE: begin
               if (bus.Start) begin
                  if (!bus.FrameBusy) begin
                     trig_q      <= 1'b1;
                     frame_cnt_q <= frame_cnt_q + 16'd1;
                     presc_q     <= 16'd0;
                     tcnt_q      <= 16'd0;
                     state_q     <= S_RUN;
                  end else begin
                     overrun_q <= 1'b1;
                     state_q   <= S_WAIT;
                  end
               end
            end
            S_RUN: begin
               // A falling Start outranks a trigger due on the same edge.
               if (!bus.Start) begin
                  state_q <= S_IDLE;
               end else if (tgt_hit) begin
                  if (!bus.FrameBusy) begin
                     trig_q      <= 1'b1;
                     frame_cnt_q <= frame_cnt_q + 16'd1;
                  end else begin
                     overrun_q <= 1'b1;
                     state_q   <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               presc_q <= presc_q;
               tcnt_q  <= tcnt_q;
               if (!bus.Start) begin
                  state_q <= S_IDLE;
               end else if (!bus.FrameBusy) begin
                  trig_q      <= 1'b1;
                  frame_cnt_q <= frame_cnt_q + 16'd1;
                  presc_q     <= 16'd0;
                  tcnt_q      <= 16'd0;
                  state_q     <= S_RUN;
               end
            end
            default: state_q <= S_HOLD;
         endcase
      end
   end

   assign bus.SubRstN   = sub_rst_n_q;
   assign bus.Ready     = ready_q;
   assign bus.FrameTrig = trig_q;
   assign bus.FrameCnt  = frame_cnt_q;
   assign bus.Overrun   = overrun_q;
   assign bus.State     = state_q;
endmodule

// File: tb/tb_trig_sequencer.sv
// Directed bench for trig_sequencer with small timing parameters; edges are
// numbered from the first rising edge after RstBtn is released.
module tb_trig_sequencer;
   localparam int NCH         = 3;
   localparam int PRE_DIV     = 4;
   localparam int RST_TICKS   = 2;
   localparam int GAP_TICKS   = 1;
   localparam int FRAME_TICKS = 3;

   logic CLK = 1'b0;
   logic RstBtn = 1'b0;
   int   errors = 0;
   int   checks = 0;
   int   cur_edge = 0;

   trig_if #(.NCH(NCH)) bus ();

   trig_sequencer #(
      .NCH(NCH), .PRE_DIV(PRE_DIV), .RST_TICKS(RST_TICKS),
      .GAP_TICKS(GAP_TICKS), .FRAME_TICKS(FRAME_TICKS)
   ) dut (
      .CLK(CLK),
      .RstBtn(RstBtn),
      .bus(bus.master)
   );

   always #5 CLK = ~CLK;

   task automatic step();
      @(posedge CLK);
      #1;
      cur_edge++;
   endtask

   task automatic go_to(input int target);
      while (cur_edge < target) step();
   endtask

   task automatic do_reset();
      RstBtn        = 1'b0;
      bus.Start     = 1'b0;
      bus.FrameBusy = 1'b0;
      @(posedge CLK);
      #1;
      RstBtn   = 1'b1;
      cur_edge = 0;
   endtask

   function automatic logic [NCH-1:0] exp_subrst(input int e);
      if (e < 8)  return 3'b000;
      if (e < 12) return 3'b001;
      if (e < 16) return 3'b011;
      return 3'b111;
   endfunction

   task automatic test_reset();
      do_reset();
      checks++; if (bus.SubRstN !== 3'b000) begin errors++; $display("FAIL reset SubRstN got %b want 000", bus.SubRstN); end
      checks++; if (bus.Ready !== 1'b0) begin errors++; $display("FAIL reset Ready got %b want 0", bus.Ready); end
      checks++; if (bus.FrameTrig !== 1'b0) begin errors++; $display("FAIL reset FrameTrig got %b want 0", bus.FrameTrig); end
      checks++; if (bus.FrameCnt !== 16'd0) begin errors++; $display("FAIL reset FrameCnt got %h want 0000", bus.FrameCnt); end
      checks++; if (bus.Overrun !== 1'b0) begin errors++; $display("FAIL reset Overrun got %b want 0", bus.Overrun); end
   endtask

   task automatic test_powerup();
      do_reset();
      for (int e = 1; e <= 29; e++) begin
         step();
         checks++; if (bus.SubRstN !== exp_subrst(e)) begin errors++; $display("FAIL powerup SubRstN e%0d got %b want %b", e, bus.SubRstN, exp_subrst(e)); end
         checks++; if (bus.Ready !== (e >= 20)) begin errors++; $display("FAIL powerup Ready e%0d got %b want %b", e, bus.Ready, (e >= 20)); end
         checks++; if (bus.FrameTrig !== 1'b0) begin errors++; $display("FAIL powerup FrameTrig e%0d got %b want 0", e, bus.FrameTrig); end
      end
   endtask

   task automatic test_start_before_ready();
      logic exp_trig;
      do_reset();
      for (int e = 1; e <= 23; e++) begin
         bus.Start     = 1'b1;
         bus.FrameBusy = (e <= 20);
         step();
         exp_trig = (e == 21);
         checks++; if (bus.FrameTrig !== exp_trig) begin errors++; $display("FAIL early_start FrameTrig e%0d got %b want %b", e, bus.FrameTrig, exp_trig); end
         checks++; if (bus.Overrun !== 1'b0) begin errors++; $display("FAIL early_start Overrun e%0d got %b want 0", e, bus.Overrun); end
      end
   endtask

   task automatic test_periodic();
      logic exp_trig;
      int   exp_cnt;
      do_reset();
      go_to(29);
      exp_cnt = 0;
      for (int e = 30; e <= 56; e++) begin
         bus.Start = 1'b1;
         step();
         exp_trig = (e == 30 || e == 42 || e == 54);
         if (exp_trig) exp_cnt++;
         checks++; if (bus.FrameTrig !== exp_trig) begin errors++; $display("FAIL periodic FrameTrig e%0d got %b want %b", e, bus.FrameTrig, exp_trig); end
         checks++; if (bus.FrameCnt !== 16'(exp_cnt)) begin errors++; $display("FAIL periodic FrameCnt e%0d got %0d want %0d", e, bus.FrameCnt, exp_cnt); end
         checks++; if (bus.Overrun !== 1'b0) begin errors++; $display("FAIL periodic Overrun e%0d got %b want 0", e, bus.Overrun); end
      end
   endtask

   task automatic test_busy_deferral();
      logic exp_trig;
      int   exp_cnt;
      do_reset();
      go_to(29);
      exp_cnt = 0;
      for (int e = 30; e <= 60; e++) begin
         bus.Start     = 1'b1;
         bus.FrameBusy = (e >= 41 && e <= 45);
         step();
         exp_trig = (e == 30 || e == 46 || e == 58);
         if (exp_trig) exp_cnt++;
         checks++; if (bus.FrameTrig !== exp_trig) begin errors++; $display("FAIL deferral FrameTrig e%0d got %b want %b", e, bus.FrameTrig, exp_trig); end
         checks++; if (bus.FrameCnt !== 16'(exp_cnt)) begin errors++; $display("FAIL deferral FrameCnt e%0d got %0d want %0d", e, bus.FrameCnt, exp_cnt); end
         checks++; if (bus.Overrun !== (e >= 42)) begin errors++; $display("FAIL deferral Overrun e%0d got %b want %b", e, bus.Overrun, (e >= 42)); end
      end
      bus.FrameBusy = 1'b0;
   endtask

   task automatic test_stop_restart();
      logic exp_trig;
      int   exp_cnt;
      do_reset();
      go_to(29);
      exp_cnt = 0;
      for (int e = 30; e <= 64; e++) begin
         bus.Start = (e < 42 || e >= 50);
         step();
         exp_trig = (e == 30 || e == 50 || e == 62);
         if (exp_trig) exp_cnt++;
         checks++; if (bus.FrameTrig !== exp_trig) begin errors++; $display("FAIL stop_restart FrameTrig e%0d got %b want %b", e, bus.FrameTrig, exp_trig); end
         checks++; if (bus.FrameCnt !== 16'(exp_cnt)) begin errors++; $display("FAIL stop_restart FrameCnt e%0d got %0d want %0d", e, bus.FrameCnt, exp_cnt); end
      end
   endtask

   task automatic test_mid_reset();
      do_reset();
      go_to(29);
      for (int e = 30; e <= 44; e++) begin
         bus.Start     = 1'b1;
         bus.FrameBusy = (e == 42);
         step();
      end
      checks++; if (bus.Overrun !== 1'b1) begin errors++; $display("FAIL mid_reset pre Overrun got %b want 1", bus.Overrun); end
      checks++; if (bus.FrameCnt !== 16'd2) begin errors++; $display("FAIL mid_reset pre FrameCnt got %0d want 2", bus.FrameCnt); end
      RstBtn = 1'b0;
      step();
      checks++; if (bus.SubRstN !== 3'b000) begin errors++; $display("FAIL mid_reset SubRstN got %b want 000", bus.SubRstN); end
      checks++; if (bus.Ready !== 1'b0) begin errors++; $display("FAIL mid_reset Ready got %b want 0", bus.Ready); end
      checks++; if (bus.FrameTrig !== 1'b0) begin errors++; $display("FAIL mid_reset FrameTrig got %b want 0", bus.FrameTrig); end
      checks++; if (bus.FrameCnt !== 16'd0) begin errors++; $display("FAIL mid_reset FrameCnt got %h want 0000", bus.FrameCnt); end
      checks++; if (bus.Overrun !== 1'b0) begin errors++; $display("FAIL mid_reset Overrun got %b want 0", bus.Overrun); end
      RstBtn        = 1'b1;
      bus.Start     = 1'b0;
      bus.FrameBusy = 1'b0;
      cur_edge      = 0;
      for (int e = 1; e <= 21; e++) begin
         step();
         checks++; if (bus.SubRstN !== exp_subrst(e)) begin errors++; $display("FAIL mid_reset powerup SubRstN e%0d got %b want %b", e, bus.SubRstN, exp_subrst(e)); end
         checks++; if (bus.Ready !== (e >= 20)) begin errors++; $display("FAIL mid_reset powerup Ready e%0d got %b want %b", e, bus.Ready, (e >= 20)); end
      end
   endtask

   task automatic test_counter_wrap();
      do_reset();
      go_to(29);
      bus.Start = 1'b1;
      go_to(35);
      // Shortcut the 65535 frames it would take to reach the wrap point.
      dut.frame_cnt_q = 16'hFFFF;
      go_to(42);
      checks++; if (bus.FrameTrig !== 1'b1) begin errors++; $display("FAIL wrap FrameTrig got %b want 1", bus.FrameTrig); end
      checks++; if (bus.FrameCnt !== 16'h0000) begin errors++; $display("FAIL wrap FrameCnt got %h want 0000", bus.FrameCnt); end
      checks++; if (bus.Overrun !== 1'b0) begin errors++; $display("FAIL wrap Overrun got %b want 0", bus.Overrun); end
      checks++; if (bus.Ready !== 1'b1) begin errors++; $display("FAIL wrap Ready got %b want 1", bus.Ready); end
      checks++; if (bus.SubRstN !== 3'b111) begin errors++; $display("FAIL wrap SubRstN got %b want 111", bus.SubRstN); end
      go_to(54);
      checks++; if (bus.FrameCnt !== 16'h0001) begin errors++; $display("FAIL wrap next FrameCnt got %h want 0001", bus.FrameCnt); end
      bus.Start = 1'b0;
   endtask

   initial begin
      bus.Start     = 1'b0;
      bus.FrameBusy = 1'b0;
      test_reset();
      test_powerup();
      test_start_before_ready();
      test_periodic();
      test_busy_deferral();
      test_stop_restart();
      test_mid_reset();
      test_counter_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
